// File: rtl/test_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// test_result_collector_pkg
// Shared types for the test result collector and its record FIFO.
//   state_t      : collector FSM states (COLLECT is the reset state)
//   result_rec_t : one result record as seen at the FIFO head (id, pass)
// ---------------------------------------------------------------------------
package test_result_collector_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // Widest test identifier the record struct can carry. The collector's
  // ID_W parameter must not exceed this; narrower ids are zero-extended.
  localparam int REC_ID_MAX = 32;

  typedef struct packed {
    logic [REC_ID_MAX-1:0] id;
    logic                  pass;
  } result_rec_t;

endpackage

// File: rtl/test_result_fifo.sv
// ---------------------------------------------------------------------------
// test_result_fifo
// Small synchronous FIFO holding accepted result records until the
// collector folds them into its counters. The head entry is readable
// combinationally so a record can be consumed on the edge after its push.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (empties FIFO)
//   push, wr_data    : write request and data (ignored when full)
//   pop              : remove head entry (ignored when empty)
//   rd_data          : current head entry
//   full, empty      : occupancy flags
//   count            : number of entries held
// ---------------------------------------------------------------------------
module test_result_fifo
  import test_result_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/test_result_collector.sv
// ---------------------------------------------------------------------------
// test_result_collector
// Accepts pass/fail result records, buffers them in a small FIFO, folds
// them one per cycle into saturating pass/fail counters, and on done_req
// drains the FIFO and presents a run summary until it is handshaken.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   res_valid/res_ready           : record handshake
//   res_id, res_pass              : record payload
//   done_req                      : end-of-run pulse (honoured in COLLECT)
//   sum_valid/sum_ready           : summary handshake
//   sum_pass_cnt, sum_fail_cnt    : saturating totals for the run
//   sum_first_fail_id             : id of first failing record, 0 if none
//   sum_any_fail                  : at least one failure this run
//   busy                          : draining or reporting
// ---------------------------------------------------------------------------
module test_result_collector
  import test_result_collector_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [ID_W-1:0]  res_id,
  input  logic             res_pass,
  input  logic             done_req,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] sum_pass_cnt,
  output logic [CNT_W-1:0] sum_fail_cnt,
  output logic [ID_W-1:0]  sum_first_fail_id,
  output logic             sum_any_fail,
  output logic             busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = ID_W + 1;

  state_t           state;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [ID_W-1:0]  first_fail_id;
  logic             any_fail;

  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic [REC_W-1:0] fifo_rd;
  logic             push;
  logic             pop;
  logic             sum_done;
  result_rec_t      head;
  logic             unused_id_hi;

  // Ready depends only on registered state, never on res_valid.
  assign res_ready = (state == COLLECT) && !fifo_full;
  assign push      = res_valid && res_ready;
  // The FIFO is always empty in REPORT, so gating pop there is only a guard.
  assign pop       = (state != REPORT) && !fifo_empty;
  assign sum_done  = (state == REPORT) && sum_ready;

  test_result_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({res_id, res_pass}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head.id      = REC_ID_MAX'(fifo_rd[REC_W-1:1]);
  assign head.pass    = fifo_rd[0];
  // Zero-extension bits above ID_W carry no information.
  assign unused_id_hi = ^(head.id >> ID_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      first_fail_id <= '0;
      any_fail      <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (done_req) state <= DRAIN;
        // No pushes happen in DRAIN, so a single remaining entry is popped
        // on this edge and the FIFO is empty once REPORT is entered.
        DRAIN:   if (fifo_empty || (fifo_count == (AW+1)'(1))) state <= REPORT;
        REPORT:  if (sum_ready) state <= COLLECT;
        default: state <= COLLECT;
      endcase

      if (sum_done) begin
        pass_cnt      <= '0;
        fail_cnt      <= '0;
        first_fail_id <= '0;
        any_fail      <= 1'b0;
      end else if (pop) begin
        if (head.pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (!any_fail) begin
            first_fail_id <= head.id[ID_W-1:0];
            any_fail      <= 1'b1;
          end
        end
      end
    end
  end

  assign sum_valid         = (state == REPORT);
  assign busy              = (state != COLLECT);
  assign sum_pass_cnt      = pass_cnt;
  assign sum_fail_cnt      = fail_cnt;
  assign sum_first_fail_id = first_fail_id;
  assign sum_any_fail      = any_fail;

endmodule
